// File: rtl/col_parity_controller.sv
// col_parity_controller
// Sequencing FSM for the column-parity (theta) datapath. Walks the 64 slices
// and, for each slice, loads the previous slice into the 25-bit register and
// the current slice onto the reader. It then steps the lane counter so the
// file writer takes one bit per cycle. Carry-outs from the datapath counters
// end each phase.
//
// Control outputs are flopped. Each one is the decode of the *next* state, so
// the registered value matches a Moore decode of the current state.

module col_parity_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] turn_in,
    input  logic       co_c64,
    input  logic       co_c25,
    output logic [4:0] turn,
    output logic       dp_start,
    output logic       ld_curr_fr,
    output logic       ld_prev_fr,
    output logic       ld_r,
    output logic       en_fw,
    output logic       init0_c64,
    output logic       init0_c25,
    output logic       en_c64,
    output logic       en_c25,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_LD_PREV = 3'd2,
        S_LD_CURR = 3'd3,
        S_CALC    = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    typedef struct packed {
        logic dp_start;
        logic ld_curr_fr;
        logic ld_prev_fr;
        logic ld_r;
        logic en_fw;
        logic init0_c64;
        logic init0_c25;
        logic en_c64;
        logic en_c25;
        logic busy;
        logic done;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [4:0] turn_q,  turn_d;
    ctrl_t      ctrl_q,  ctrl_d;

    // Control strobes asserted in a given state; IDLE and unused codes give all-zero.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = ctrl_t'(11'd0);
        case (s)
            S_INIT: begin
                c.dp_start  = 1'b1;
                c.init0_c64 = 1'b1;
                c.init0_c25 = 1'b1;
                c.busy      = 1'b1;
            end
            S_LD_PREV: begin
                // Reader presents slice (z-1) mod 64 and the register grabs it on the same edge.
                c.ld_prev_fr = 1'b1;
                c.ld_r       = 1'b1;
                c.busy       = 1'b1;
            end
            S_LD_CURR: begin
                c.ld_curr_fr = 1'b1;
                c.busy       = 1'b1;
            end
            S_CALC: begin
                c.en_fw  = 1'b1;
                c.en_c25 = 1'b1;
                c.busy   = 1'b1;
            end
            S_NEXT: begin
                c.en_c64 = 1'b1;
                c.busy   = 1'b1;
            end
            S_DONE: begin
                c.busy = 1'b1;
                c.done = 1'b1;
            end
            default: begin
                c = ctrl_t'(11'd0);
            end
        endcase
        return c;
    endfunction

    // Next-state, turn capture and next-cycle control decode.
    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    turn_d  = turn_in;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                state_d = S_LD_PREV;
            end
            S_LD_PREV: begin
                state_d = S_LD_CURR;
            end
            S_LD_CURR: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                // Lane 24 is written in the carry cycle; the counter wraps itself.
                if (co_c25) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_NEXT: begin
                if (co_c64) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LD_PREV;
                end
            end
            S_DONE: begin
                // start is deliberately not looked at here.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ctrl_d = decode_ctrl(state_d);
    end

    // State, captured turn and flopped control strobes with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            turn_q  <= 5'd0;
            ctrl_q  <= ctrl_t'(11'd0);
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign turn       = turn_q;
    assign dp_start   = ctrl_q.dp_start;
    assign ld_curr_fr = ctrl_q.ld_curr_fr;
    assign ld_prev_fr = ctrl_q.ld_prev_fr;
    assign ld_r       = ctrl_q.ld_r;
    assign en_fw      = ctrl_q.en_fw;
    assign init0_c64  = ctrl_q.init0_c64;
    assign init0_c25  = ctrl_q.init0_c25;
    assign en_c64     = ctrl_q.en_c64;
    assign en_c25     = ctrl_q.en_c25;
    assign busy       = ctrl_q.busy;
    assign done       = ctrl_q.done;

endmodule

// File: tb/tb_col_parity_controller.sv
// Directed testbench for col_parity_controller. Behavioural models of the
// slice and lane counters close the carry loop. Each test task drives its
// own scenario and compares against hand-derived cycle numbers.

module tb_col_parity_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] turn_in = 5'd0;
    logic       co_c64, co_c25;
    logic [4:0] turn;
    logic       dp_start, ld_curr_fr, ld_prev_fr, ld_r, en_fw;
    logic       init0_c64, init0_c25, en_c64, en_c25, busy, done;

    int total = 0;
    int bad   = 0;

    // counter models and carry overrides
    logic [5:0] c64 = 6'd0;
    logic [4:0] c25 = 5'd0;
    logic       force_c64 = 1'b0;
    logic       hold_c25_low = 1'b0;

    assign co_c64 = force_c64 ? 1'b1 : (c64 == 6'd63);
    assign co_c25 = hold_c25_low ? 1'b0 : (c25 == 5'd24);

    col_parity_controller dut (
        .clk(clk), .rst(rst), .start(start), .turn_in(turn_in),
        .co_c64(co_c64), .co_c25(co_c25), .turn(turn),
        .dp_start(dp_start), .ld_curr_fr(ld_curr_fr), .ld_prev_fr(ld_prev_fr),
        .ld_r(ld_r), .en_fw(en_fw), .init0_c64(init0_c64), .init0_c25(init0_c25),
        .en_c64(en_c64), .en_c25(en_c25), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // datapath counters: synchronous clear has priority over increment
    always @(posedge clk) begin
        if (init0_c64) c64 <= 6'd0;
        else if (en_c64) c64 <= c64 + 6'd1;
        if (init0_c25) c25 <= 5'd0;
        else if (en_c25) c25 <= (c25 == 5'd24) ? 5'd0 : c25 + 5'd1;
    end

    wire [15:0] outs = {turn, dp_start, ld_curr_fr, ld_prev_fr, ld_r, en_fw,
                        init0_c64, init0_c25, en_c64, en_c25, busy, done};

    // results of the most recent run_pass
    int r_done1, r_done2, r_ndone, r_first_enfw, r_busy_bad, r_turn_bad;
    int r_overlap, r_enfw_gap, r_c64_total;
    int n_prev, n_ldr, n_curr, n_c64, n_fw, n_c25, n_dps, n_i64, n_i25, n_done;
    logic [15:0] r_post_rst;
    logic [4:0]  r_turn_end;

    // Start a pass at cycle 0, then run ncyc cycles. Extra start pulses go at
    // p1/p2/p3, turn_in switches to tval from cycle tchg, and rst is raised in
    // cycle rcyc (-1 = never).
    task automatic run_pass(input logic [4:0] tin, input int p1, input int p2, input int p3,
                            input int tchg, input logic [4:0] tval, input int rcyc,
                            input int ncyc);
        r_done1 = -1; r_done2 = -1; r_ndone = 0; r_first_enfw = -1;
        r_busy_bad = 0; r_turn_bad = 0; r_overlap = 0; r_enfw_gap = 0; r_c64_total = 0;
        n_prev = 0; n_ldr = 0; n_curr = 0; n_c64 = 0; n_fw = 0; n_c25 = 0;
        n_dps = 0; n_i64 = 0; n_i25 = 0; n_done = 0;
        r_post_rst = 16'hffff;
        @(negedge clk);
        start = 1'b1;
        turn_in = tin;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(negedge clk);
            if (done) begin
                r_ndone++;
                if (r_done1 < 0) r_done1 = cyc;
                else if (r_done2 < 0) r_done2 = cyc;
            end
            if (r_done1 < 0 || r_done1 == cyc) begin
                n_prev += int'(ld_prev_fr); n_ldr += int'(ld_r); n_curr += int'(ld_curr_fr);
                n_c64 += int'(en_c64); n_fw += int'(en_fw); n_c25 += int'(en_c25);
                n_dps += int'(dp_start); n_i64 += int'(init0_c64); n_i25 += int'(init0_c25);
                n_done += int'(done);
                if (busy !== 1'b1) r_busy_bad++;
                if (turn !== tin) r_turn_bad++;
            end
            if (en_fw && r_first_enfw < 0) r_first_enfw = cyc;
            if ((int'(ld_prev_fr) + int'(ld_curr_fr) + int'(en_fw)) > 1) r_overlap++;
            if (cyc >= 4 && !en_fw) r_enfw_gap++;
            r_c64_total += int'(en_c64);
            if (cyc == rcyc + 1) r_post_rst = outs;
            r_turn_end = turn;
            start   = (cyc == p1 || cyc == p2 || cyc == p3);
            turn_in = (tchg >= 0 && cyc >= tchg) ? tval : tin;
            rst     = (cyc == rcyc);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset;
        // rst with start high, then rst with start low: every output stays 0
        rst = 1'b1; start = 1'b1; turn_in = 5'd19;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (outs !== 16'd0) begin
                bad++;
                $display("FAIL reset_outs cycle %0d: got %h want 0000", i, outs);
            end
            if (i == 2) start = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || outs !== 16'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got %h want 0000", outs);
        end
    endtask

    task automatic test_full_pass;
        run_pass(5'd7, -1, -1, -1, -1, 5'd0, -1, 1800);
        total++; if (r_done1 !== 1794) begin bad++; $display("FAIL done_cycle got %0d want 1794", r_done1); end
        total++; if (r_ndone !== 1) begin bad++; $display("FAIL done_count got %0d want 1", r_ndone); end
        total++; if (r_turn_bad !== 0) begin bad++; $display("FAIL turn_held bad cycles %0d want 0", r_turn_bad); end
        total++; if (r_busy_bad !== 0) begin bad++; $display("FAIL busy_high bad cycles %0d want 0", r_busy_bad); end
        total++; if (n_prev !== 64 || n_ldr !== 64) begin bad++; $display("FAIL ld_prev_ldr got %0d/%0d want 64/64", n_prev, n_ldr); end
        total++; if (n_curr !== 64 || n_c64 !== 64) begin bad++; $display("FAIL ld_curr_en_c64 got %0d/%0d want 64/64", n_curr, n_c64); end
        total++; if (n_fw !== 1600 || n_c25 !== 1600) begin bad++; $display("FAIL en_fw_en_c25 got %0d/%0d want 1600/1600", n_fw, n_c25); end
        total++; if (n_dps !== 1 || n_i64 !== 1 || n_i25 !== 1 || n_done !== 1) begin
            bad++; $display("FAIL single_pulses got %0d/%0d/%0d/%0d want 1/1/1/1", n_dps, n_i64, n_i25, n_done); end
        total++; if (r_first_enfw !== 4) begin bad++; $display("FAIL first_en_fw got %0d want 4", r_first_enfw); end
        total++; if (r_overlap !== 0) begin bad++; $display("FAIL strobe_overlap got %0d want 0", r_overlap); end
        total++; if (busy !== 1'b0 || turn !== 5'd7) begin bad++; $display("FAIL idle_after_pass busy=%b turn=%0d want 0/7", busy, turn); end
    endtask

    task automatic test_start_ignored_and_turn;
        // starts in cycle 100 and in DONE (1794) are ignored; 1795 starts pass 2
        run_pass(5'd7, 100, 1794, 1795, 50, 5'd23, -1, 1795 + 1794 + 3);
        total++; if (r_done1 !== 1794) begin bad++; $display("FAIL ignore_start_done1 got %0d want 1794", r_done1); end
        total++; if (r_done2 !== 3589) begin bad++; $display("FAIL second_pass_done got %0d want 3589", r_done2); end
        total++; if (r_ndone !== 2) begin bad++; $display("FAIL two_pass_done_count got %0d want 2", r_ndone); end
        total++; if (r_turn_bad !== 0) begin bad++; $display("FAIL turn_in_change_ignored bad cycles %0d want 0", r_turn_bad); end
        total++; if (r_turn_end !== 5'd23) begin bad++; $display("FAIL turn_recaptured got %0d want 23", r_turn_end); end
    endtask

    task automatic test_reset_mid_pass;
        run_pass(5'd7, -1, -1, -1, -1, 5'd0, 900, 1000);
        total++; if (r_post_rst !== 16'd0) begin bad++; $display("FAIL abort_outs got %h want 0000", r_post_rst); end
        total++; if (r_ndone !== 0) begin bad++; $display("FAIL abort_no_done got %0d want 0", r_ndone); end
        run_pass(5'd7, -1, -1, -1, -1, 5'd0, -1, 1800);
        total++; if (r_done1 !== 1794 || n_fw !== 1600) begin
            bad++; $display("FAIL pass_after_abort done=%0d en_fw=%0d want 1794/1600", r_done1, n_fw); end
    endtask

    task automatic test_force_carry;
        // slice-0 NEXT is cycle 29, so DONE lands in cycle 30
        force_c64 = 1'b1;
        run_pass(5'd3, -1, -1, -1, -1, 5'd0, -1, 40);
        force_c64 = 1'b0;
        total++; if (r_done1 !== 30) begin bad++; $display("FAIL forced_co_c64_done got %0d want 30", r_done1); end
        total++; if (r_c64_total !== 1 || r_ndone !== 1) begin
            bad++; $display("FAIL forced_single_slice en_c64=%0d done=%0d want 1/1", r_c64_total, r_ndone); end
    endtask

    task automatic test_stuck_calc;
        hold_c25_low = 1'b1;
        run_pass(5'd9, -1, -1, -1, -1, 5'd0, -1, 200);
        total++; if (r_enfw_gap !== 0) begin bad++; $display("FAIL stuck_calc_en_fw gaps %0d want 0", r_enfw_gap); end
        total++; if (r_c64_total !== 0 || r_ndone !== 0) begin
            bad++; $display("FAIL stuck_calc_no_next en_c64=%0d done=%0d want 0/0", r_c64_total, r_ndone); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold_c25_low = 1'b0;
        total++; if (busy !== 1'b0 || outs !== 16'd0) begin bad++; $display("FAIL stuck_recover got %h want 0000", outs); end
    endtask

    initial begin
        test_reset;
        test_full_pass;
        test_start_ignored_and_turn;
        test_reset_mid_pass;
        test_force_carry;
        test_stuck_calc;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
